mac_rx_dispatch: RTL
====================

// Module: mac_rx_dispatch
// PURPOSE
//  Receive-side counterpart of the two-input transmit arbiter. Sits between the
//  10G MAC RX AXIS output and the upper layers. Classifies each received frame
//  by EtherType on its first beat and steers the whole frame to the ARP port
//  (c0) or the IP port (c1). Unknown types are dropped. RX path has no
//  back-pressure (valid-only AXIS).
// PARAMETERS
//  P_ARP_TYPE   16'h0806   EtherType routed to c0
//  P_IP_TYPE    16'h0800   EtherType routed to c1
//  P_USER_W     80         user width {16'len, 48'peer_mac, 16'type}
// PORTS
//  i_clk            in   1         XGMII clock, only clock
//  i_rst            in   1         asynchronous, active-low reset
//  s_axis_rdata     in   64        MAC RX data
//  s_axis_ruser     in   P_USER_W  MAC RX user; [15:0]=EtherType, valid on first beat
//  s_axis_rkeep     in   8         byte enables
//  s_axis_rlast     in   1         last beat
//  s_axis_rvalid    in   1         beat valid (gaps allowed mid-frame)
//  m_axis_c0_data/user/keep/last/valid  out 64/P_USER_W/8/1/1  ARP stream
//  m_axis_c1_data/user/keep/last/valid  out 64/P_USER_W/8/1/1  IP stream
//  o_busy           out  1         frame in progress (state != IDLE)
// BEHAVIOUR
//  - Reset (i_rst low): all outputs 0, state IDLE, latched user 0. Asserted
//    mid-frame: frame abandoned, no partial last emitted.
//  - States: IDLE, FWD_C0, FWD_C1, DROP.
//  - IDLE + rvalid = first beat: type=s_axis_ruser[15:0]; ==P_ARP_TYPE -> C0,
//    ==P_IP_TYPE -> C1, else DROP. If rlast on same beat (1-beat frame): beat
//    forwarded/dropped, state stays IDLE.
//  - FWD_Cx/DROP: each rvalid beat forwarded to port x (or discarded); on
//    rvalid&&rlast -> IDLE. Next cycle may carry next frame's first beat.
//  - User field latched on first beat; every forwarded beat of the frame
//    carries the latched value (mid-frame ruser changes ignored).
//  - Latency: fixed 1 cycle, all m_* registered. data/keep/last/user copied
//    verbatim; valid of the non-selected port is 0. At most one port valid per
//    cycle. Idle cycles / gaps: both valids 0, data/keep/last hold last value.
//  - rvalid=0 mid-frame: state held, nothing emitted.
//  - keep not checked; rkeep=0 beat is forwarded as-is.
// CONFIGURATION
//  MAC_RX_DISPATCH_STATS_EN defined: adds outputs o_arp_frm_cnt, o_ip_frm_cnt,
//  o_drop_frm_cnt (each 16-bit, saturating at 16'hFFFF, reset 0), incremented
//  on the first beat of each classified frame. Undefined: ports and counters
//  absent; routing behaviour identical.
// TESTING
//  T1 type 16'h0806, 8 beats, last keep 8'h0F -> 8 beats on c0 one cycle later,
//     c1_valid never high, last keep 8'h0F.
//  T2 type 16'h0800, 5 beats with 2-cycle valid gap after beat 2 -> 5 beats on
//     c1, gap reproduced, user constant = first-beat user.
//  T3 type 16'h86DD, 4 beats -> no valid on either port; with STATS_EN
//     o_drop_frm_cnt=1.
//  T4 back-to-back: ARP frame last beat then IP first beat next cycle -> c0 last
//     then c1 first on consecutive cycles, no lost beat.
//  T5 single-beat IP frame (valid&last together) -> one c1 beat with last=1,
//     o_busy stays 0.
//  T6 i_rst low on beat 3 of 6-beat IP frame, released, new ARP frame -> outputs
//     0 during reset, remaining old beats treated as new frames by type, ARP
//     frame routed to c0.

Source files
------------

// File: rtl/mac_rx_dispatch.sv
// Receive-side EtherType dispatcher: steers each MAC RX frame to the ARP (c0) or IP (c1) stream, drops others.
// Optional per-class frame counters are enabled by defining MAC_RX_DISPATCH_STATS_EN.
module mac_rx_dispatch #(
    parameter logic [15:0] P_ARP_TYPE = 16'h0806,
    parameter logic [15:0] P_IP_TYPE  = 16'h0800,
    parameter int          P_USER_W   = 80
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [63:0]         s_axis_rdata,
    input  logic [P_USER_W-1:0] s_axis_ruser,
    input  logic [7:0]          s_axis_rkeep,
    input  logic                s_axis_rlast,
    input  logic                s_axis_rvalid,
    output logic [63:0]         m_axis_c0_data,
    output logic [P_USER_W-1:0] m_axis_c0_user,
    output logic [7:0]          m_axis_c0_keep,
    output logic                m_axis_c0_last,
    output logic                m_axis_c0_valid,
    output logic [63:0]         m_axis_c1_data,
    output logic [P_USER_W-1:0] m_axis_c1_user,
    output logic [7:0]          m_axis_c1_keep,
    output logic                m_axis_c1_last,
    output logic                m_axis_c1_valid,
    output logic                o_busy
`ifdef MAC_RX_DISPATCH_STATS_EN
    ,
    output logic [15:0]         o_arp_frm_cnt,
    output logic [15:0]         o_ip_frm_cnt,
    output logic [15:0]         o_drop_frm_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FWD_C0, FWD_C1, DROP} state_t;

    state_t              state_reg, state_next, first_dest, route;
    logic                first_beat;
    logic [1:0]          fwd_en;
    logic [P_USER_W-1:0] user_reg;
    logic [P_USER_W-1:0] beat_user;

    always_comb begin
        first_dest = DROP;
        if (s_axis_ruser[15:0] == P_ARP_TYPE)
            first_dest = FWD_C0;
        else if (s_axis_ruser[15:0] == P_IP_TYPE)
            first_dest = FWD_C1;
    end

    assign first_beat = (state_reg == IDLE) && s_axis_rvalid;
    // The first beat's user must already be the latched value, so bypass the register.
    assign beat_user  = first_beat ? s_axis_ruser : user_reg;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg <= IDLE;
            user_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (first_beat)
                user_reg <= s_axis_ruser;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (s_axis_rvalid && !s_axis_rlast) state_next = first_dest;
            default: if (s_axis_rvalid && s_axis_rlast)  state_next = IDLE;
        endcase
    end

    always_comb begin
        fwd_en = 2'b00;
        o_busy = (state_reg != IDLE);
        route  = (state_reg == IDLE) ? first_dest : state_reg;
        if (s_axis_rvalid) begin
            fwd_en[0] = (route == FWD_C0);
            fwd_en[1] = (route == FWD_C1);
        end
    end

    // One registered output stage per port; non-forwarding cycles hold the last beat's fields.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [63:0]         data_reg;
            logic [P_USER_W-1:0] user_out_reg;
            logic [7:0]          keep_reg;
            logic                last_reg;
            logic                valid_reg;

            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    data_reg     <= '0;
                    user_out_reg <= '0;
                    keep_reg     <= '0;
                    last_reg     <= 1'b0;
                    valid_reg    <= 1'b0;
                end else begin
                    valid_reg <= fwd_en[gi];
                    if (fwd_en[gi]) begin
                        data_reg     <= s_axis_rdata;
                        user_out_reg <= beat_user;
                        keep_reg     <= s_axis_rkeep;
                        last_reg     <= s_axis_rlast;
                    end
                end
            end
        end
    endgenerate

    assign m_axis_c0_data  = g_port[0].data_reg;
    assign m_axis_c0_user  = g_port[0].user_out_reg;
    assign m_axis_c0_keep  = g_port[0].keep_reg;
    assign m_axis_c0_last  = g_port[0].last_reg;
    assign m_axis_c0_valid = g_port[0].valid_reg;
    assign m_axis_c1_data  = g_port[1].data_reg;
    assign m_axis_c1_user  = g_port[1].user_out_reg;
    assign m_axis_c1_keep  = g_port[1].keep_reg;
    assign m_axis_c1_last  = g_port[1].last_reg;
    assign m_axis_c1_valid = g_port[1].valid_reg;

`ifdef MAC_RX_DISPATCH_STATS_EN
    logic [15:0] arp_cnt_reg, ip_cnt_reg, drop_cnt_reg;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            arp_cnt_reg  <= '0;
            ip_cnt_reg   <= '0;
            drop_cnt_reg <= '0;
        end else if (first_beat) begin
            if (first_dest == FWD_C0 && arp_cnt_reg != 16'hFFFF)
                arp_cnt_reg <= arp_cnt_reg + 16'd1;
            if (first_dest == FWD_C1 && ip_cnt_reg != 16'hFFFF)
                ip_cnt_reg <= ip_cnt_reg + 16'd1;
            if (first_dest == DROP && drop_cnt_reg != 16'hFFFF)
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign o_arp_frm_cnt  = arp_cnt_reg;
    assign o_ip_frm_cnt   = ip_cnt_reg;
    assign o_drop_frm_cnt = drop_cnt_reg;
`endif

endmodule
